// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus issue controller feeding a UART transmitter.
//
// The core pushes bytes at full clock rate. One byte at a time is popped and
// presented to the transmitter as a single-cycle tx_valid_o strobe. The block
// then waits for the transmitter's single-cycle tx_ready_i done pulse before
// it issues the next byte.
//
// Optional feature: define UART_TX_FIFO_TIMEOUT_EN to bound the wait for
// tx_ready_i to TIMEOUT_CYCLES cycles. On expiry the sticky tx_timeout_o is set
// and the in-flight byte is abandoned. Without the macro the wait is unbounded
// and tx_timeout_o is tied low.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   wr_en_i      push wr_data_i this cycle (dropped if full)
//   wr_data_i    byte to enqueue
//   full_o       count_o == DEPTH
//   empty_o      count_o == 0
//   count_o      bytes held, excluding the byte in flight
//   overflow_o   sticky: a push was dropped because the FIFO was full
//   busy_o       issue controller not idle, or FIFO non-empty
//   tx_valid_o   one-cycle strobe to the transmitter
//   tx_data_o    byte to the transmitter, held until the next issue
//   tx_ready_i   one-cycle done pulse from the transmitter
//   tx_timeout_o sticky timeout flag
module uart_tx_fifo #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [7:0]               wr_data_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     busy_o,
  output logic                     tx_valid_o,
  output logic [7:0]               tx_data_o,
  input  logic                     tx_ready_i,
  output logic                     tx_timeout_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;

`ifdef UART_TX_FIFO_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tx_timeout_q, tx_timeout_d;
`endif

  assign full_o       = (count_q == (AW + 1)'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign overflow_o   = overflow_q;
  assign busy_o       = (state_q != StIdle) || !empty_o;
  assign tx_valid_o   = tx_valid_q;
  assign tx_data_o    = tx_data_q;

  // Push acceptance uses the pre-edge full flag, even when a pop happens in
  // the same cycle, so a push into a full FIFO is always dropped.
  assign push = wr_en_i && !full_o;
  assign pop  = (state_q == StIdle) && !empty_o;

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    overflow_d = overflow_q;
`ifdef UART_TX_FIFO_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    tx_timeout_d = tx_timeout_q;
`endif

    case (state_q)
      StIdle: begin
        if (!empty_o) begin
          tx_data_d  = mem_q[rd_ptr_q];
          tx_valid_d = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        tx_valid_d = 1'b0;
        state_d    = StWait;
`ifdef UART_TX_FIFO_TIMEOUT_EN
        tmo_cnt_d  = '0;
`endif
      end
      StWait: begin
        // tx_ready_i is only honoured here; a stray pulse in the other states
        // belongs to a frame started before reset.
        if (tx_ready_i) begin
          state_d = StIdle;
`ifdef UART_TX_FIFO_TIMEOUT_EN
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tx_timeout_d = 1'b1;
          state_d      = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (wr_en_i && full_o) begin
      overflow_d = 1'b1;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

`ifdef UART_TX_FIFO_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q    <= '0;
      tx_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q    <= tmo_cnt_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end

  assign tx_timeout_o = tx_timeout_q;
`else
  assign tx_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// queue-based behavioural model.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TMO   = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          tx_ready;
  logic          full, empty, overflow, busy, tx_valid, tx_timeout;
  logic [CW-1:0] count;
  logic [7:0]    tx_data;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wr_en_i      (wr_en),
    .wr_data_i    (wr_data),
    .full_o       (full),
    .empty_o      (empty),
    .count_o      (count),
    .overflow_o   (overflow),
    .busy_o       (busy),
    .tx_valid_o   (tx_valid),
    .tx_data_o    (tx_data),
    .tx_ready_i   (tx_ready),
    .tx_timeout_o (tx_timeout)
  );

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model: a queue of stored bytes plus the in-flight transfer.
  logic [7:0] q[$];
  bit         m_inflight;   // a byte has been popped and not yet completed
  bit         m_strobe;     // the popped byte is being strobed this cycle
  bit         m_over;
  bit         m_tmo;
  logic [7:0] m_data;
  int         m_wait;       // cycles already spent waiting for done

  bit cmp_en    = 1'b0;
  int rdy_cd    = 0;
  int burst_idx = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_inflight = 1'b0;
    m_strobe   = 1'b0;
    m_over     = 1'b0;
    m_tmo      = 1'b0;
    m_data     = 8'h00;
    m_wait     = 0;
  endtask

  // Advance the model across one rising edge using the inputs driven for it.
  task automatic model_step();
    bit was_full;
    if (rst) begin
      model_reset();
      return;
    end
    was_full = (q.size() == DEPTH);
    if (!m_inflight) begin
      if (q.size() > 0) begin
        m_data     = q.pop_front();
        m_strobe   = 1'b1;
        m_inflight = 1'b1;
      end
    end else if (m_strobe) begin
      m_strobe = 1'b0;
      m_wait   = 0;
    end else if (tx_ready) begin
      m_inflight = 1'b0;
`ifdef UART_TX_FIFO_TIMEOUT_EN
    end else if (m_wait == TMO - 1) begin
      m_tmo      = 1'b1;
      m_inflight = 1'b0;
    end else begin
      m_wait++;
`endif
    end
    if (wr_en) begin
      if (was_full) m_over = 1'b1;
      else          q.push_back(wr_data);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("count",      int'(count),      q.size());
      chk("full",       int'(full),       int'(q.size() == DEPTH));
      chk("empty",      int'(empty),      int'(q.size() == 0));
      chk("busy",       int'(busy),       int'(m_inflight || q.size() > 0));
      chk("tx_valid",   int'(tx_valid),   int'(m_strobe));
      chk("tx_data",    int'(tx_data),    int'(m_data));
      chk("overflow",   int'(overflow),   int'(m_over));
      chk("tx_timeout", int'(tx_timeout), int'(m_tmo));
    end
  end

  task automatic cyc(input bit w, input logic [7:0] d, input bit r);
    wr_en    = w;
    wr_data  = d;
    tx_ready = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    rdy_cd = 0;
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  // One cycle with a transmitter that answers each strobe after lo..hi cycles.
  task automatic step_resp(input bit w, input logic [7:0] d, input int lo, input int hi,
                           input int stray_pct, input bit track);
    bit r;
    r = 1'b0;
    if (rdy_cd > 0) begin
      rdy_cd--;
      if (rdy_cd == 0) r = 1'b1;
    end
    if (stray_pct > 0 && int'($urandom_range(0, 99)) < stray_pct) r = 1'b1;
    cyc(w, d, r);
    if (m_strobe) rdy_cd = int'($urandom_range(lo, hi));
    if (track && tx_valid) begin
      chk("burst_order", int'(tx_data), burst_idx);
      burst_idx++;
    end
  endtask

  task automatic run(input int n, input int wr_pct, input int lo, input int hi,
                     input int stray_pct);
    for (int i = 0; i < n; i++) begin
      step_resp(int'($urandom_range(0, 99)) < wr_pct, 8'($urandom), lo, hi, stray_pct, 1'b0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    tx_ready = 1'b0;
    model_reset();
    cmp_en   = 1'b1;
    do_reset();

    // Reset values.
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(tx_valid), 0);
    chk("rst_data", int'(tx_data), 0);
    chk("rst_overflow", int'(overflow), 0);

    // Single byte: strobe appears two edges after the push, for one cycle.
    cyc(1'b1, 8'hA5, 1'b0);
    chk("single_count", int'(count), 1);
    chk("single_nvalid", int'(tx_valid), 0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("single_valid", int'(tx_valid), 1);
    chk("single_data", int'(tx_data), 8'hA5);
    chk("single_popped", int'(count), 0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("single_strobe_len", int'(tx_valid), 0);
    chk("single_hold", int'(tx_data), 8'hA5);
    chk("single_busy", int'(busy), 1);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("single_done", int'(busy), 0);

    // Overflow: with done held off, 17 pushes fit (one is popped), the 18th drops.
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("ovf_count16", int'(count), 16);
    chk("ovf_full", int'(full), 1);
    chk("ovf_clear", int'(overflow), 0);
    cyc(1'b1, 8'h11, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_count_kept", int'(count), 16);
    // Push while full in the same cycle as a pop: the push is still dropped.
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'hEE, 1'b0);
    chk("simul_count", int'(count), 15);
    chk("simul_valid", int'(tx_valid), 1);
    chk("simul_data", int'(tx_data), 8'h01);
    rdy_cd = 3;
    run(400, 0, 2, 12, 0);
    chk("ovf_drained", int'(busy), 0);

    // Reset while waiting with five bytes stored.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    chk("midrst_count5", int'(count), 5);
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_count", int'(count), 0);
    chk("midrst_empty", int'(empty), 1);
    chk("midrst_valid", int'(tx_valid), 0);
    chk("midrst_idle", int'(busy), 0);
    cyc(1'b0, 8'h00, 1'b0);
    rst = 1'b0;

    // Burst of 16 with done 10 cycles after each strobe.
    do_reset();
    burst_idx = 0;
    for (int i = 0; i < 16; i++) step_resp(1'b1, 8'(i), 10, 10, 0, 1'b1);
    for (int i = 0; i < 220; i++) step_resp(1'b0, 8'h00, 10, 10, 0, 1'b1);
    chk("burst_strobes", burst_idx, 16);
    chk("burst_overflow", int'(overflow), 0);

`ifdef UART_TX_FIFO_TIMEOUT_EN
    // Timeout: WAIT entered two edges after the push, expiry eight later.
    do_reset();
    cyc(1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 8'h00, 1'b0);
    chk("tmo_not_yet", int'(tx_timeout), 0);
    chk("tmo_busy", int'(busy), 1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("tmo_set", int'(tx_timeout), 1);
    chk("tmo_idle", int'(busy), 0);
    cyc(1'b1, 8'h5A, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("tmo_next_valid", int'(tx_valid), 1);
    chk("tmo_next_data", int'(tx_data), 8'h5A);
    rdy_cd = 3;
    run(20, 0, 2, 6, 0);
`endif

    // Randomized traffic: light load, heavy load with overflow, then drain.
    do_reset();
    run(1500, 30, 2, 12, 2);
    run(1500, 90, 2, 12, 1);
    run(600, 5, 2, 6, 0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
